// File: rtl/data_sram_like_slave_if.sv
// CPU data-memory request/response bundle: one-cycle request handshake on addr_ok, fixed-latency response on data_ok.
// The master issues load/store requests; the slave returns completions in issue order.
interface data_sram_like_slave_if;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    modport master (
        output data_req, data_wr, data_size, data_addr, data_wdata,
        input  data_addr_ok, data_data_ok, data_rdata
    );

    modport slave (
        input  data_req, data_wr, data_size, data_addr, data_wdata,
        output data_addr_ok, data_data_ok, data_rdata
    );
endinterface

// File: rtl/data_sram_like_slave.sv
// Data-memory responder: byte-strobed stores, raw-word loads, in-order responses LATENCY cycles after accept.
// Back-pressure: addr_ok drops when QDEPTH requests are outstanding or (STALL_EN) when the LFSR low bits are zero.
module data_sram_like_slave #(
    parameter int          ADDR_W    = 12,
    parameter int          LATENCY   = 2,
    parameter int          QDEPTH    = 4,
    parameter int          STALL_EN  = 0,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                  clk,
    input  logic                  rst,
    data_sram_like_slave_if.slave bus
);
    localparam int CNT_W = $clog2(QDEPTH + 1);

    typedef struct packed {
        logic        vld;
        logic [31:0] dat;
    } rsp_t;

    rsp_t              pipe_q [LATENCY];
    rsp_t              pipe_d [LATENCY];
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [15:0]       lfsr_q, lfsr_d;
    logic [31:0]       mem [2**ADDR_W];

    logic              stall;
    logic              accept;
    logic              wr_en;
    logic              misal;
    logic [3:0]        strb;
    logic [ADDR_W-1:0] idx;
    logic              unused_addr_hi;

    // Upper address bits alias onto the implemented word range.
    assign idx            = bus.data_addr[ADDR_W+1:2];
    assign unused_addr_hi = ^bus.data_addr[31:ADDR_W+2];

    assign stall            = (STALL_EN != 0) && (lfsr_q[1:0] == 2'b00);
    assign bus.data_addr_ok = ~rst & (cnt_q < CNT_W'(QDEPTH)) & ~stall;
    assign accept           = bus.data_req & bus.data_addr_ok;
    assign wr_en            = accept & bus.data_wr & ~misal;

    always_comb begin
        strb  = 4'b0000;
        misal = 1'b0;
        case (bus.data_size)
            2'd0: strb = 4'b0001 << bus.data_addr[1:0];
            2'd1: begin
                strb  = 4'b0011 << bus.data_addr[1:0];
                misal = bus.data_addr[0];
            end
            default: begin
                strb  = 4'b1111;
                misal = |bus.data_addr[1:0];
            end
        endcase
    end

    // Load data is captured at accept so later stores cannot disturb an in-flight response.
    always_comb begin
        pipe_d[0].vld = accept;
        pipe_d[0].dat = (accept && !bus.data_wr) ? mem[idx] : 32'h0;
        for (int i = 1; i < LATENCY; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (accept && !bus.data_data_ok) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (!accept && bus.data_data_ok) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            lfsr_q <= LFSR_SEED;
            for (int i = 0; i < LATENCY; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            cnt_q  <= cnt_d;
            lfsr_q <= lfsr_d;
            pipe_q <= pipe_d;
        end
    end

    // Memory contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (strb[b]) begin
                    mem[idx][8*b +: 8] <= bus.data_wdata[8*b +: 8];
                end
            end
        end
    end

    assign bus.data_data_ok = pipe_q[LATENCY-1].vld;
    assign bus.data_rdata   = pipe_q[LATENCY-1].dat;
endmodule
